// File: rtl/ais_hdlc_rx_ctrl.sv
// AIS HDLC receive frame controller: NRZI decode, flag hunt, zero-bit destuffing and LSB-first byte framing.
// Define CRC16_CHECK_EN to add the CRC-16/X.25 FCS check; otherwise crc_ok is tied high.
module ais_hdlc_rx_ctrl #(
  parameter int MAX_BYTES = 64,
  parameter int MIN_BYTES = 3
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       bit_vld,
  input  logic       data_demo,
  output logic       data_denrzi,
  output logic [7:0] byte_data,
  output logic       byte_vld,
  output logic       frame_sof,
  output logic       frame_eof,
  output logic       frame_err,
  output logic [7:0] frame_len,
  output logic       crc_ok
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    FLAG = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0] MAX_B = 8'(MAX_BYTES);
  localparam logic [7:0] MIN_B = 8'(MIN_BYTES);

  state_t     state_q;
  logic       prev_q;
  logic [2:0] ones_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] byte_cnt_q;
  logic [7:0] shift_q;
  logic       data_denrzi_q;
  logic [7:0] byte_data_q;
  logic       byte_vld_q;
  logic       frame_sof_q;
  logic       frame_eof_q;
  logic       frame_err_q;
  logic [7:0] frame_len_q;

  logic       dec_s;
  logic       is_flag_s;
  logic       is_abort_s;
  logic       is_stuff_s;
  logic       in_data_s;
  logic       flag_abort_s;
  logic       abort_s;
  logic       close_s;
  logic       data_bit_s;
  logic       byte_done_s;
  logic       ovf_s;
  logic       emit_s;
  logic       eof_s;
  logic       close_err_s;
  logic [2:0] ones_d;
  logic [7:0] shift_d;

  // Decode the current bit and classify it against the run of preceding ones.
  always_comb begin
    dec_s        = ~(data_demo ^ prev_q);
    is_flag_s    = (dec_s == 1'b0) && (ones_q == 3'd6);
    is_abort_s   = (dec_s == 1'b1) && (ones_q == 3'd6);
    is_stuff_s   = (dec_s == 1'b0) && (ones_q == 3'd5);
    ones_d       = dec_s ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;
    shift_d      = {dec_s, shift_q[7:1]};
    // After a flag, the first non-flag, non-abort bit is already frame content.
    in_data_s    = (state_q == DATA) || ((state_q == FLAG) && !is_flag_s && !is_abort_s);
    flag_abort_s = bit_vld && (state_q == FLAG) && is_abort_s;
    abort_s      = bit_vld && in_data_s && is_abort_s;
    close_s      = bit_vld && in_data_s && is_flag_s;
    data_bit_s   = bit_vld && in_data_s && !is_stuff_s && !is_flag_s && !is_abort_s;
    byte_done_s  = data_bit_s && (bit_cnt_q == 3'd7);
    ovf_s        = byte_done_s && (byte_cnt_q >= MAX_B);
    emit_s       = byte_done_s && (byte_cnt_q < MAX_B);
    eof_s        = close_s && (bit_cnt_q == 3'd7) && (byte_cnt_q >= MIN_B);
    close_err_s  = close_s && !((bit_cnt_q == 3'd7) && ((byte_cnt_q >= MIN_B) || (byte_cnt_q == 8'd0)));
  end

  // Frame FSM with registered strobes, counters and shifter.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q       <= HUNT;
      prev_q        <= 1'b1;
      ones_q        <= 3'd0;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= 8'd0;
      shift_q       <= 8'd0;
      data_denrzi_q <= 1'b0;
      byte_data_q   <= 8'd0;
      byte_vld_q    <= 1'b0;
      frame_sof_q   <= 1'b0;
      frame_eof_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_len_q   <= 8'd0;
    end else begin
      byte_vld_q  <= emit_s;
      frame_sof_q <= emit_s && (byte_cnt_q == 8'd0);
      frame_eof_q <= eof_s;
      frame_err_q <= ovf_s || abort_s || close_err_s;
      if (emit_s) begin
        byte_data_q <= shift_d;
      end
      if (close_s || abort_s || ovf_s) begin
        frame_len_q <= byte_cnt_q;
      end
      if (bit_vld) begin
        prev_q        <= data_demo;
        data_denrzi_q <= dec_s;
        ones_q        <= ones_d;
        case (state_q)
          HUNT: begin
            if (is_flag_s) begin
              state_q    <= FLAG;
              bit_cnt_q  <= 3'd0;
              byte_cnt_q <= 8'd0;
            end
          end
          FLAG, DATA: begin
            if (flag_abort_s || abort_s || ovf_s) begin
              state_q    <= HUNT;
              bit_cnt_q  <= 3'd0;
              byte_cnt_q <= 8'd0;
            end else if (is_flag_s) begin
              state_q    <= FLAG;
              bit_cnt_q  <= 3'd0;
              byte_cnt_q <= 8'd0;
            end else begin
              state_q <= DATA;
              if (data_bit_s) begin
                shift_q   <= shift_d;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (emit_s) begin
                  byte_cnt_q <= byte_cnt_q + 8'd1;
                end
              end
            end
          end
          default: begin
            state_q <= HUNT;
          end
        endcase
      end
    end
  end

`ifdef CRC16_CHECK_EN
  logic [15:0] crc_q;
  logic        crc_ok_q;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  // FCS accumulator: restarts at every flag, absorbs each emitted byte.
  always_ff @(posedge sclk) begin
    if (rst) begin
      crc_q    <= 16'hFFFF;
      crc_ok_q <= 1'b0;
    end else begin
      crc_ok_q <= eof_s && (crc_q == 16'hF0B8);
      if (bit_vld && is_flag_s) begin
        crc_q <= 16'hFFFF;
      end else if (emit_s) begin
        crc_q <= crc16_byte(crc_q, shift_d);
      end else begin
        crc_q <= crc_q;
      end
    end
  end

  assign crc_ok = crc_ok_q;
`else
  assign crc_ok = 1'b1;
`endif

  assign data_denrzi = data_denrzi_q;
  assign byte_data   = byte_data_q;
  assign byte_vld    = byte_vld_q;
  assign frame_sof   = frame_sof_q;
  assign frame_eof   = frame_eof_q;
  assign frame_err   = frame_err_q;
  assign frame_len   = frame_len_q;

endmodule

// File: tb/tb_ais_hdlc_rx_ctrl.sv
// Bench for ais_hdlc_rx_ctrl: an HDLC/NRZI encoder drives bits, expected strobes go to a scoreboard queue.
`timescale 1ns/1ps
module tb_ais_hdlc_rx_ctrl;
  localparam int MAX_BYTES = 64;
  localparam int MIN_BYTES = 3;
`ifdef CRC16_CHECK_EN
  localparam logic RST_CRC_OK = 1'b0;
`else
  localparam logic RST_CRC_OK = 1'b1;
`endif

  // kind = {byte_vld, frame_sof, frame_eof, frame_err}
  typedef struct packed {
    logic [3:0] kind;
    logic [7:0] data;
    logic [7:0] len;
  } ev_t;

  logic       sclk      = 1'b0;
  logic       rst       = 1'b1;
  logic       bit_vld   = 1'b0;
  logic       data_demo = 1'b1;
  logic       data_denrzi;
  logic [7:0] byte_data;
  logic       byte_vld;
  logic       frame_sof;
  logic       frame_eof;
  logic       frame_err;
  logic [7:0] frame_len;
  logic       crc_ok;

  ev_t        sb_q[$];
  ev_t        mon_ev;
  logic [7:0] frame_q[$];
  int         tests_run    = 0;
  int         tests_failed = 0;
  logic       line_lvl     = 1'b1;
  int         stuff_cnt    = 0;

  always #5 sclk = ~sclk;

  ais_hdlc_rx_ctrl #(.MAX_BYTES(MAX_BYTES), .MIN_BYTES(MIN_BYTES)) dut (
    .sclk(sclk), .rst(rst), .bit_vld(bit_vld), .data_demo(data_demo),
    .data_denrzi(data_denrzi), .byte_data(byte_data), .byte_vld(byte_vld),
    .frame_sof(frame_sof), .frame_eof(frame_eof), .frame_err(frame_err),
    .frame_len(frame_len), .crc_ok(crc_ok)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc16_x25(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  task automatic push_ev(input logic [3:0] kind, input logic [7:0] data, input logic [7:0] len);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.len  = len;
    sb_q.push_back(e);
  endtask

  // NRZI encoder: a decoded 1 keeps the line level, a 0 toggles it.
  task automatic send_bit(input logic d);
    @(negedge sclk);
    data_demo = d ? line_lvl : ~line_lvl;
    line_lvl  = data_demo;
    bit_vld   = 1'b1;
    @(negedge sclk);
    bit_vld   = 1'b0;
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    stuff_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (b[i]) begin
        stuff_cnt++;
        if (stuff_cnt == 5) begin
          send_bit(1'b0);
          stuff_cnt = 0;
        end
      end else begin
        stuff_cnt = 0;
      end
    end
  endtask

  // Flag, frame_q bytes (plus FCS when asked), flag; expected strobes queued first.
  task automatic send_frame(input logic add_fcs);
    logic [15:0] crc;
    logic [7:0]  full[$];
    int          n;
    crc = 16'hFFFF;
    foreach (frame_q[i]) crc = crc16_x25(crc, frame_q[i]);
    full = frame_q;
    if (add_fcs) begin
      full.push_back(~crc[7:0]);
      full.push_back(~crc[15:8]);
    end
    n = full.size();
    foreach (full[i]) push_ev((i == 0) ? 4'b1100 : 4'b1000, full[i], 8'd0);
    if (n >= MIN_BYTES) push_ev(4'b0010, 8'd0, 8'(n));
    else                push_ev(4'b0001, 8'd0, 8'(n));
    send_flag();
    foreach (full[i]) send_byte(full[i]);
    send_flag();
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_denrzi"}, 32'(data_denrzi), 32'd0);
    check_val({tag, "_byte_data"}, 32'(byte_data), 32'd0);
    check_val({tag, "_strobes"}, 32'({byte_vld, frame_sof, frame_eof, frame_err}), 32'd0);
    check_val({tag, "_frame_len"}, 32'(frame_len), 32'd0);
    check_val({tag, "_crc_ok"}, 32'(crc_ok), 32'(RST_CRC_OK));
  endtask

  // Scoreboard: every strobe cycle must match the oldest queued expectation.
  always @(posedge sclk) begin
    #1;
    if (byte_vld || frame_sof || frame_eof || frame_err) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_strobe", 32'({byte_vld, frame_sof, frame_eof, frame_err}), 32'd0);
      end else begin
        mon_ev = sb_q.pop_front();
        check_val("strobe_kind", 32'({byte_vld, frame_sof, frame_eof, frame_err}), 32'(mon_ev.kind));
        if (byte_vld) check_val("byte_data", 32'(byte_data), 32'(mon_ev.data));
        if (frame_eof || frame_err) check_val("frame_len", 32'(frame_len), 32'(mon_ev.len));
        if (frame_eof) check_val("crc_ok", 32'(crc_ok), 32'd1);
      end
    end
  end

  initial begin
    // Reset with a pending bit: reset must win.
    rst       = 1'b1;
    bit_vld   = 1'b1;
    data_demo = 1'b0;
    repeat (3) @(negedge sclk);
    check_reset_state("reset");
    rst       = 1'b0;
    bit_vld   = 1'b0;
    data_demo = 1'b1;

    for (int i = 0; i < 7; i++) begin
      send_bit(1'b1);
      check_val("denrzi_idle", 32'(data_denrzi), 32'd1);
    end

    frame_q = '{8'h12, 8'h34, 8'h56};
    send_frame(1'b1);

    frame_q = '{8'hFF, 8'h1F};
    send_frame(1'b1);

    // Abort: seven ones after one byte.
    send_flag();
    push_ev(4'b1100, 8'h12, 8'd0);
    push_ev(4'b0001, 8'd0, 8'd1);
    send_byte(8'h12);
    for (int i = 0; i < 7; i++) send_bit(1'b1);

    // Misaligned: three zero bits then a flag; the flag's 0,1111 completes byte 0xF0.
    send_flag();
    push_ev(4'b1100, 8'hF0, 8'd0);
    push_ev(4'b0001, 8'd0, 8'd1);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    send_flag();

    frame_q = '{8'hAA, 8'h55};
    send_frame(1'b0);

    send_flag();
    send_flag();
    send_flag();
    frame_q = '{8'hA5, 8'h3C};
    send_frame(1'b1);

    // Overflow: the byte past MAX_BYTES becomes an error.
    send_flag();
    for (int i = 0; i < MAX_BYTES; i++) push_ev((i == 0) ? 4'b1100 : 4'b1000, 8'(i * 29 + 3), 8'd0);
    push_ev(4'b0001, 8'd0, 8'(MAX_BYTES));
    for (int i = 0; i <= MAX_BYTES; i++) send_byte(8'(i * 29 + 3));

    // Reset mid-byte, then a normal frame.
    send_flag();
    push_ev(4'b1100, 8'h12, 8'd0);
    send_byte(8'h12);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge sclk);
    rst       = 1'b1;
    bit_vld   = 1'b1;
    data_demo = ~line_lvl;
    @(negedge sclk);
    check_reset_state("midrst");
    rst       = 1'b0;
    bit_vld   = 1'b0;
    data_demo = 1'b1;
    line_lvl  = 1'b1;
    stuff_cnt = 0;
    frame_q = '{8'h12, 8'h34, 8'h56};
    send_frame(1'b1);

    repeat (4) @(negedge sclk);
    check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
